// File: rtl/exec_pkg.sv
// Shared opcodes, counter width and state/class types for the ALU execute-stage sequencer.
package exec_pkg;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_LV   = 5'd1;
    localparam logic [4:0] OP_MLT  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_REST = 5'd4;
    localparam logic [4:0] OP_SUM  = 5'd5;
    localparam logic [4:0] OP_CP   = 5'd6;
    localparam logic [4:0] OP_B    = 5'd7;
    localparam logic [4:0] OP_BEG  = 5'd8;
    localparam logic [4:0] OP_SLR  = 5'd9;
    localparam logic [4:0] OP_GP   = 5'd10;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    typedef enum logic [2:0] {CL_NOP, CL_WB, CL_BR, CL_BEG, CL_ILL} op_class_e;

endpackage

// File: rtl/exec_op_decode.sv
// Combinational opcode decode: retirement class and execute latency (as latency-1 for
// direct counter load).
module exec_op_decode
    import exec_pkg::*;
#(
    parameter int unsigned LAT_BASE = 1,
    parameter int unsigned LAT_MUL  = 2,
    parameter int unsigned LAT_DIV  = 4
) (
    input  logic [4:0]       i_opcode,
    output op_class_e        o_class,
    output logic [CNT_W-1:0] o_lat_m1
);

    always_comb begin
        o_lat_m1 = CNT_W'(LAT_BASE - 1);
        if (i_opcode == OP_MLT) begin
            o_lat_m1 = CNT_W'(LAT_MUL - 1);
        end else if (i_opcode == OP_DIV) begin
            o_lat_m1 = CNT_W'(LAT_DIV - 1);
        end
    end

    always_comb begin
        o_class = CL_ILL;
        case (i_opcode)
            OP_NOP:  o_class = CL_NOP;
            OP_B:    o_class = CL_BR;
            OP_BEG:  o_class = CL_BEG;
            OP_LV, OP_MLT, OP_DIV, OP_REST, OP_SUM, OP_CP, OP_SLR, OP_GP: o_class = CL_WB;
            default: o_class = CL_ILL;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: registers ALU operands, holds them for an opcode-dependent
// number of cycles, then retires the ALU outputs as a writeback, branch pulse or flag.
module alu_exec_ctrl
    import exec_pkg::*;
#(
    parameter int unsigned LAT_BASE = 1,
    parameter int unsigned LAT_MUL  = 2,
    parameter int unsigned LAT_DIV  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [6:0]  in_rd,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rsi,
    input  logic [31:0] in_rt,
    output logic [4:0]  alu_opcode,
    output logic [6:0]  alu_rd,
    output logic [31:0] alu_rs,
    output logic [31:0] alu_rsi,
    output logic [31:0] alu_rt,
    input  logic [31:0] alu_result,
    input  logic [6:0]  alu_rdout,
    input  logic [6:0]  alu_branch,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_opcode,
    output logic [6:0]  out_rd,
    output logic [31:0] out_result,
    output logic        out_div0,
    output logic        br_taken,
    output logic [6:0]  br_target,
    output logic        illegal
);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;

    op_class_e        w_in_cls;
    op_class_e        w_alu_cls;
    logic [CNT_W-1:0] w_in_lat_m1;
    logic [CNT_W-1:0] w_alu_lat_m1;
    logic             w_accept;
    logic             w_unused_dec;

    // Latency comes from the incoming opcode (counter load); class from the held opcode.
    exec_op_decode #(
        .LAT_BASE (LAT_BASE),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV)
    ) u_dec_in (
        .i_opcode (in_opcode),
        .o_class  (w_in_cls),
        .o_lat_m1 (w_in_lat_m1)
    );

    exec_op_decode #(
        .LAT_BASE (LAT_BASE),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV)
    ) u_dec_alu (
        .i_opcode (alu_opcode),
        .o_class  (w_alu_cls),
        .o_lat_m1 (w_alu_lat_m1)
    );

    assign w_unused_dec = ^{3'(w_in_cls), w_alu_lat_m1};

    assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            alu_opcode <= '0;
            alu_rd     <= '0;
            alu_rs     <= '0;
            alu_rsi    <= '0;
            alu_rt     <= '0;
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_rd     <= '0;
            out_result <= '0;
            out_div0   <= 1'b0;
            br_taken   <= 1'b0;
            br_target  <= '0;
            illegal    <= 1'b0;
        end else begin
            br_taken  <= 1'b0;
            br_target <= '0;
            illegal   <= 1'b0;
            case (r_state)
                EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= IDLE;
                        case (w_alu_cls)
                            CL_WB: begin
                                r_state    <= DONE;
                                out_valid  <= 1'b1;
                                out_opcode <= alu_opcode;
                                out_rd     <= alu_rdout;
                                if ((alu_opcode == OP_DIV) && (alu_rt == '0)) begin
                                    out_result <= '1;
                                    out_div0   <= 1'b1;
                                end else begin
                                    out_result <= alu_result;
                                    out_div0   <= 1'b0;
                                end
                            end
                            CL_BR: begin
                                br_taken  <= 1'b1;
                                br_target <= alu_branch;
                            end
                            CL_BEG: begin
                                if (alu_result == 32'd1) begin
                                    br_taken  <= 1'b1;
                                    br_target <= alu_branch;
                                end
                            end
                            CL_ILL:  illegal <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_div0  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: ;
            endcase
            // Accept overrides the IDLE/DONE exit so a retire+accept edge goes straight to EXEC.
            if (w_accept) begin
                r_state    <= EXEC;
                r_cnt      <= w_in_lat_m1;
                alu_opcode <= in_opcode;
                alu_rd     <= in_rd;
                alu_rs     <= in_rs;
                alu_rsi    <= in_rsi;
                alu_rt     <= in_rt;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: directed scenarios plus randomized back-to-back
// traffic checked against a spec-level model, with a behavioural ALU stub.
module tb_alu_exec_ctrl;

    localparam int unsigned LAT_BASE = 1;
    localparam int unsigned LAT_MUL  = 2;
    localparam int unsigned LAT_DIV  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [6:0]  in_rd;
    logic [31:0] in_rs, in_rsi, in_rt;
    logic [4:0]  alu_opcode;
    logic [6:0]  alu_rd;
    logic [31:0] alu_rs, alu_rsi, alu_rt;
    logic [31:0] alu_result;
    logic [6:0]  alu_rdout;
    logic [6:0]  alu_branch;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_opcode;
    logic [6:0]  out_rd;
    logic [31:0] out_result;
    logic        out_div0;
    logic        br_taken;
    logic [6:0]  br_target;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(
        .LAT_BASE (LAT_BASE),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_rsi     (in_rsi),
        .in_rt      (in_rt),
        .alu_opcode (alu_opcode),
        .alu_rd     (alu_rd),
        .alu_rs     (alu_rs),
        .alu_rsi    (alu_rsi),
        .alu_rt     (alu_rt),
        .alu_result (alu_result),
        .alu_rdout  (alu_rdout),
        .alu_branch (alu_branch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_result (out_result),
        .out_div0   (out_div0),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .illegal    (illegal)
    );

    wire [107:0] alu_vec = {alu_opcode, alu_rd, alu_rs, alu_rsi, alu_rt};
    wire [162:0] all_out = {alu_vec, out_valid, out_opcode, out_rd, out_result, out_div0,
                            br_taken, br_target, illegal};

    // Behavioural ALU stub; div-by-zero returns a marker the sequencer must override.
    function automatic logic [31:0] alu_res(input logic [4:0] op, input logic [6:0] rd,
                                            input logic [31:0] rs, input logic [31:0] rsi,
                                            input logic [31:0] rt);
        case (op)
            5'd1:    return rt;
            5'd2:    return rs * rt;
            5'd3:    return (rt == 32'd0) ? 32'h0000_1234 : rs / rt;
            5'd4:    return (rt == 32'd0) ? 32'd0 : rs % rt;
            5'd5:    return rs + rt;
            5'd6:    return rs;
            5'd8:    return ({25'd0, rd} >= rs) ? 32'd1 : 32'd0;
            5'd9:    return rs >> rt[4:0];
            5'd10:   return rsi;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [6:0] alu_br(input logic [4:0] op, input logic [6:0] rd,
                                          input logic [31:0] rt);
        if (op == 5'd7) return rd;
        if (op == 5'd8) return rt[6:0];
        return 7'd0;
    endfunction

    always_comb begin
        alu_result = alu_res(alu_opcode, alu_rd, alu_rs, alu_rsi, alu_rt);
        alu_branch = alu_br(alu_opcode, alu_rd, alu_rt);
        alu_rdout  = alu_rd;
    end

    function automatic int exp_lat(input logic [4:0] op);
        if (op == 5'd2) return LAT_MUL;
        if (op == 5'd3) return LAT_DIV;
        return LAT_BASE;
    endfunction

    // 0 nop, 1 writeback, 2 branch, 3 conditional branch, 4 illegal
    function automatic int exp_kind(input logic [4:0] op);
        if (op == 5'd0) return 0;
        if (op == 5'd7) return 2;
        if (op == 5'd8) return 3;
        if (op <= 5'd10) return 1;
        return 4;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] op, input logic [6:0] rd, input logic [31:0] rs,
                          input logic [31:0] rsi, input logic [31:0] rt);
        in_opcode = op;
        in_rd     = rd;
        in_rs     = rs;
        in_rsi    = rsi;
        in_rt     = rt;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_in(5'd5, 7'd1, 32'd1, 32'd1, 32'd1);
        step;
        step;
        n_vec++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0;
        step;
    endtask

    task automatic test_sum;
        out_ready = 1'b1;
        set_in(5'd5, 7'd3, 32'd7, 32'd0, 32'd5);
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, alu_vec} !== {2'b00, 5'd5, 7'd3, 32'd7, 32'd0, 32'd5}) begin
            n_err++;
            $display("FAIL sum_exec: got %h want %h", {out_valid, in_ready, alu_vec},
                     {2'b00, 5'd5, 7'd3, 32'd7, 32'd0, 32'd5});
        end
        step;
        n_vec++;
        if ({out_valid, out_opcode, out_rd, out_result, out_div0, in_ready} !==
            {1'b1, 5'd5, 7'd3, 32'd12, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sum_result: got v=%b op=%0d rd=%0d res=%0d d0=%b rdy=%b want 1/5/3/12/0/1",
                     out_valid, out_opcode, out_rd, out_result, out_div0, in_ready);
        end
        step;
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL sum_retire: got v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_multicycle;
        logic [4:0]  t_op  [3] = '{5'd2, 5'd3, 5'd3};
        logic [31:0] t_rs  [3] = '{32'd6, 32'd100, 32'd9};
        logic [31:0] t_rt  [3] = '{32'd7, 32'd7, 32'd0};
        logic [31:0] t_res [3] = '{32'd42, 32'd14, 32'hFFFF_FFFF};
        logic        t_d0  [3] = '{1'b0, 1'b0, 1'b1};
        int          t_lat [3] = '{2, 4, 4};
        logic [107:0] exp_alu;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_alu = {t_op[i], 7'd10, t_rs[i], 32'd0, t_rt[i]};
            set_in(t_op[i], 7'd10, t_rs[i], 32'd0, t_rt[i]);
            in_valid = 1'b1;
            step;
            set_in(5'd1, 7'h7f, 32'hdead_beef, 32'hcafe_f00d, 32'h1);
            n_vec++;
            if (alu_vec !== exp_alu) begin
                n_err++;
                $display("FAIL mc_load[%0d]: got %h want %h", i, alu_vec, exp_alu);
            end
            for (int k = 1; k < t_lat[i]; k++) begin
                step;
                n_vec++;
                if ({out_valid, alu_vec} !== {1'b0, exp_alu}) begin
                    n_err++;
                    $display("FAIL mc_hold[%0d] cyc %0d: got v=%b alu=%h want 0 %h", i, k,
                             out_valid, alu_vec, exp_alu);
                end
            end
            in_valid = 1'b0;
            step;
            n_vec++;
            if ({out_valid, out_result, out_div0} !== {1'b1, t_res[i], t_d0[i]}) begin
                n_err++;
                $display("FAIL mc_result[%0d]: got v=%b res=%h d0=%b want 1 %h %b", i,
                         out_valid, out_result, out_div0, t_res[i], t_d0[i]);
            end
            step;
            n_vec++;
            if ({out_valid, out_div0} !== 2'b00) begin
                n_err++;
                $display("FAIL mc_retire[%0d]: got v=%b d0=%b want 0 0", i, out_valid, out_div0);
            end
        end
    endtask

    task automatic test_branches;
        logic [4:0]  t_op [3] = '{5'd7, 5'd8, 5'd8};
        logic [6:0]  t_rd [3] = '{7'h15, 7'd9, 7'd4};
        logic [31:0] t_rs [3] = '{32'd0, 32'd4, 32'd9};
        logic [31:0] t_rt [3] = '{32'd0, 32'h22, 32'h22};
        logic        t_tk [3] = '{1'b1, 1'b1, 1'b0};
        logic [6:0]  t_tg [3] = '{7'h15, 7'h22, 7'h00};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(t_op[i], t_rd[i], t_rs[i], 32'd0, t_rt[i]);
            in_valid = 1'b1;
            step;
            in_valid = 1'b0;
            step;
            n_vec++;
            if ({br_taken, br_target, out_valid} !== {t_tk[i], t_tg[i], 1'b0}) begin
                n_err++;
                $display("FAIL branch[%0d]: got tk=%b tg=%h v=%b want %b %h 0", i, br_taken,
                         br_target, out_valid, t_tk[i], t_tg[i]);
            end
            step;
            n_vec++;
            if ({br_taken, br_target, out_valid, in_ready} !== {1'b0, 7'd0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL branch_pulse[%0d]: got tk=%b tg=%h v=%b rdy=%b want 0 0 0 1", i,
                         br_taken, br_target, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        set_in(5'd5, 7'd6, 32'd20, 32'd0, 32'd22);
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        n_vec++;
        if ({out_valid, out_result, out_rd, in_ready} !== {1'b1, 32'd42, 7'd6, 1'b0}) begin
            n_err++;
            $display("FAIL bp_capture: got v=%b res=%0d rd=%0d rdy=%b want 1 42 6 0", out_valid,
                     out_result, out_rd, in_ready);
        end
        set_in(5'd2, 7'd9, 32'd6, 32'd0, 32'd7);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step;
            n_vec++;
            if ({out_valid, out_result, out_rd, out_opcode, in_ready, alu_opcode} !==
                {1'b1, 32'd42, 7'd6, 5'd5, 1'b0, 5'd5}) begin
                n_err++;
                $display("FAIL bp_hold cyc %0d: got v=%b res=%0d rd=%0d op=%0d rdy=%b aop=%0d", k,
                         out_valid, out_result, out_rd, out_opcode, in_ready, alu_opcode);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready: got %b want 1", in_ready);
        end
        step;
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, alu_opcode, alu_rs, alu_rt} !== {1'b0, 5'd2, 32'd6, 32'd7}) begin
            n_err++;
            $display("FAIL bp_same_edge: got v=%b aop=%0d rs=%0d rt=%0d want 0 2 6 7", out_valid,
                     alu_opcode, alu_rs, alu_rt);
        end
        step;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_early: got v=%b want 0", out_valid);
        end
        step;
        n_vec++;
        if ({out_valid, out_result, out_rd} !== {1'b1, 32'd42, 7'd9}) begin
            n_err++;
            $display("FAIL bp_next: got v=%b res=%0d rd=%0d want 1 42 9", out_valid, out_result,
                     out_rd);
        end
        step;
    endtask

    task automatic test_illegal_nop;
        logic [4:0] t_op  [2] = '{5'd13, 5'd0};
        logic       t_ill [2] = '{1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_in(t_op[i], 7'd2, 32'd3, 32'd4, 32'd5);
            in_valid = 1'b1;
            step;
            in_valid = 1'b0;
            step;
            n_vec++;
            if ({illegal, br_taken, out_valid, in_ready} !== {t_ill[i], 1'b0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL ill_nop[%0d]: got ill=%b tk=%b v=%b rdy=%b want %b 0 0 1", i,
                         illegal, br_taken, out_valid, in_ready, t_ill[i]);
            end
            step;
            n_vec++;
            if ({illegal, out_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL ill_pulse[%0d]: got ill=%b v=%b want 0 0", i, illegal, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        set_in(5'd3, 7'd11, 32'd50, 32'd0, 32'd5);
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        n_vec++;
        if ({all_out, in_ready} !== {163'd0, 1'b1}) begin
            n_err++;
            $display("FAIL rst_mid: got %h rdy=%b want 0 1", all_out, in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            step;
            n_vec++;
            if ({out_valid, br_taken, illegal} !== 3'b000) begin
                n_err++;
                $display("FAIL rst_mid_quiet cyc %0d: got v=%b tk=%b ill=%b want 0", k,
                         out_valid, br_taken, illegal);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  op;
        logic [6:0]  rd;
        logic [31:0] rs, rsi, rt, exp_r;
        logic        exp_tk;
        logic [6:0]  exp_tg;
        int          kind, lat, stall;
        for (int i = 0; i < 150; i++) begin
            op   = 5'($urandom_range(0, 15));
            rd   = 7'($urandom);
            rs   = (op == 5'd8) ? 32'($urandom_range(0, 127)) : $urandom;
            rsi  = $urandom;
            rt   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            kind = exp_kind(op);
            lat  = exp_lat(op);
            out_ready = 1'b1;
            set_in(op, rd, rs, rsi, rt);
            in_valid = 1'b1;
            #1;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL rnd_ready[%0d]: got %b want 1", i, in_ready);
            end
            step;
            in_valid = 1'($urandom_range(0, 1));
            set_in(5'($urandom), 7'($urandom), $urandom, $urandom, $urandom);
            n_vec++;
            if ({alu_vec, out_valid, br_taken, illegal} !== {op, rd, rs, rsi, rt, 3'b000}) begin
                n_err++;
                $display("FAIL rnd_accept[%0d]: got %h v=%b tk=%b ill=%b want %h 0 0 0", i,
                         alu_vec, out_valid, br_taken, illegal, {op, rd, rs, rsi, rt});
            end
            for (int k = 1; k < lat; k++) begin
                step;
                n_vec++;
                if ({alu_vec, out_valid} !== {op, rd, rs, rsi, rt, 1'b0}) begin
                    n_err++;
                    $display("FAIL rnd_exec[%0d] cyc %0d: got %h v=%b", i, k, alu_vec, out_valid);
                end
            end
            step;
            in_valid = 1'b0;
            if (kind == 1) begin
                exp_r = ((op == 5'd3) && (rt == 32'd0)) ? 32'hFFFF_FFFF
                                                        : alu_res(op, rd, rs, rsi, rt);
                n_vec++;
                if ({out_valid, out_opcode, out_rd, out_result, out_div0} !==
                    {1'b1, op, rd, exp_r, (op == 5'd3) && (rt == 32'd0)}) begin
                    n_err++;
                    $display("FAIL rnd_wb[%0d] op %0d: got v=%b op=%0d rd=%0d res=%h d0=%b want res=%h",
                             i, op, out_valid, out_opcode, out_rd, out_result, out_div0, exp_r);
                end
                stall = $urandom_range(0, 3);
                if (stall > 0) out_ready = 1'b0;
                for (int k = 0; k < stall; k++) begin
                    step;
                    n_vec++;
                    if ({out_valid, out_result, in_ready} !== {1'b1, exp_r, 1'b0}) begin
                        n_err++;
                        $display("FAIL rnd_stall[%0d]: got v=%b res=%h rdy=%b want 1 %h 0", i,
                                 out_valid, out_result, in_ready, exp_r);
                    end
                end
                if ($urandom_range(0, 2) == 0) begin
                    out_ready = 1'b1;
                    step;
                    n_vec++;
                    if ({out_valid, out_div0, in_ready} !== 3'b001) begin
                        n_err++;
                        $display("FAIL rnd_retire[%0d]: got v=%b d0=%b rdy=%b want 0 0 1", i,
                                 out_valid, out_div0, in_ready);
                    end
                end
            end else begin
                exp_tk = (kind == 2) || ((kind == 3) && ({25'd0, rd} >= rs));
                exp_tg = !exp_tk ? 7'd0 : (kind == 2) ? rd : rt[6:0];
                n_vec++;
                if ({out_valid, br_taken, br_target, illegal} !==
                    {1'b0, exp_tk, exp_tg, kind == 4}) begin
                    n_err++;
                    $display("FAIL rnd_nowb[%0d] op %0d: got v=%b tk=%b tg=%h ill=%b want 0 %b %h %b",
                             i, op, out_valid, br_taken, br_target, illegal, exp_tk, exp_tg,
                             kind == 4);
                end
            end
        end
        out_ready = 1'b1;
        step;
        step;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_sum;
        test_multicycle;
        test_branches;
        test_backpressure;
        test_illegal_nop;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute-stage sequencer wrapped around the combinational ALU (opcodes 0–10: NOP, LV, mlt, div, rest, sum, CP, B, BEG, slr, GP).
- Accepts one decoded instruction at a time over a valid/ready handshake and registers the ALU operands.
- Holds those operands for an opcode-dependent number of cycles so mlt/div can be multicycle-constrained, then captures the ALU outputs.
- Writeback results go out over a valid/ready handshake; branch outcomes go out as one-cycle pulses.

Parameters:
- LAT_BASE, 1, execute cycles for all single-cycle opcodes (must be ≥1).
- LAT_MUL, 2, execute cycles for opcode 2 (mlt) (must be ≥1).
- LAT_DIV, 4, execute cycles for opcode 3 (div) (must be ≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  block can accept an instruction.
- in_opcode  in  5  opcode.
- in_rd  in  7  destination / branch target field.
- in_rs, in_rsi, in_rt  in  32 each  operand values.
- alu_opcode  out  5  registered opcode to ALU.
- alu_rd  out  7  registered Rd to ALU.
- alu_rs, alu_rsi, alu_rt  out  32 each  registered operands to ALU.
- alu_result  in  32  ALU AluResult.
- alu_rdout  in  7  ALU RdOut.
- alu_branch  in  7  ALU branchResult.
- out_valid  out  1  writeback result valid.
- out_ready  in  1  writeback stage accepts.
- out_opcode  out  5  retired opcode.
- out_rd  out  7  destination register.
- out_result  out  32  result value.
- out_div0  out  1  div retired with Rt==0.
- br_taken  out  1  one-cycle pulse, branch taken.
- br_target  out  7  target, valid while br_taken=1.
- illegal  out  1  one-cycle pulse, opcode 11–31 retired.

Behaviour:
- Reset: synchronous, active-high. State=IDLE; every output and alu_* register = 0 (alu_opcode=0 is NOP); counter=0. Reset in any state aborts the in-flight instruction with no output, pulse or flag.
- States: IDLE, EXEC, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept on edge where in_valid & in_ready:
  - load alu_* from in_*; state→EXEC;
  - counter = LAT−1, where LAT = LAT_MUL for op 2, LAT_DIV for op 3, else LAT_BASE.
- EXEC: alu_* held stable. Counter decrements each cycle. Capture happens on the edge where counter==0, so capture is exactly LAT edges after the accept edge.
- At capture, by opcode class:
  - Writeback ops 1,2,3,4,5,6,9,10:
    - out_opcode=alu_opcode, out_rd=alu_rdout, out_result=alu_result;
    - out_valid=1; state→DONE.
  - Div by zero (op 3 with alu_rt==0): out_result=32'hFFFF_FFFF and out_div0=1, overriding the ALU output. out_div0=0 for all other retirements.
  - B (op 7): br_taken=1, br_target=alu_branch, state→IDLE, no out_valid.
  - BEG (op 8): br_taken = (alu_result==1), br_target=alu_branch, state→IDLE.
  - NOP (op 0): state→IDLE; no output or pulse.
  - Op 11–31: illegal=1 for one cycle; state→IDLE; ALU z-output is ignored.
- br_taken and illegal are high for exactly the one cycle following the capture edge.
- br_target is 0 whenever br_taken=0.
- DONE: out_* held stable while out_ready=0.
  - On out_valid & out_ready: out_valid→0, out_div0→0.
  - If the same edge also accepts a new instruction, go directly to EXEC (zero bubble). Otherwise go to IDLE.
- Back-to-back single-cycle ops with out_ready=1 sustain one retirement every 2 cycles (accept→EXEC→DONE+accept).
- in_* are ignored whenever in_ready=0.
- Opcode class and latency are decided from the registered alu_opcode, never from in_opcode after the accept edge.

Decomposition:
- exec_pkg holds:
  - opcode localparams OP_NOP=0 … OP_GP=10;
  - state enum {IDLE, EXEC, DONE};
  - op-class enum {CL_NOP, CL_WB, CL_BR, CL_BEG, CL_ILL}.
- One sub-module, exec_op_decode (combinational): opcode → {class, latency} using the three parameters. Instantiated once on in_opcode (for the counter load) and once on alu_opcode (for capture).

Test Plan:
- Sum: rst 2 cycles, then accept op 5, rd=3, rs=7, rt=5 at edge T. Expect out_valid high after edge T+1 with out_result=12, out_rd=3. With out_ready=1 it drops the next cycle and in_ready=1.
- Multicycle ops: mlt rs=6, rt=7 → out_valid first high after edge T+2, result 42. div rs=100, rt=7 → result 14 after edge T+4, alu_* stable through EXEC. div rs=9, rt=0 → result FFFF_FFFF, out_div0=1.
- Branches: B rd=0x15 → single-cycle br_taken=1, br_target=0x15, out_valid never rises. BEG rd=9, rs=4, rt=0x22 → br_taken=1, br_target=0x22. BEG rd=4, rs=9 → br_taken=0.
- Backpressure: sum retires with out_ready=0 for 5 cycles → out_* constant, in_ready=0. Raise out_ready with in_valid=1 (op 2) → retire and accept on the same edge; next result is 2 cycles later.
- Illegal/NOP: op 13 → illegal pulses one cycle, no out_valid. Op 0 → returns to IDLE after LAT_BASE, no pulses.
- Reset mid-op: rst asserted during div EXEC cycle 2 → next cycle state IDLE, all outputs 0. After rst drops, the div never retires.
